uart_cmd_frame_ctrl: RTL and testbench

//  Drains bytes from the UART_RX_FIFO read port, assembles fixed 8-byte command frames, and validates sync and checksum.

---
 rtl/uart_cmd_pkg.sv | 38 +++
 rtl/frame_timeout_timer.sv | 34 +++
 rtl/uart_cmd_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame controller:
// FSM state encoding, frame constants, opcodes and the frame checksum.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_POP   = 3'd1,
    S_CAPT  = 3'd2,
    S_CHECK = 3'd3,
    S_ISSUE = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 8;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;

  // Modulo-256 sum of opcode, address and the four data bytes.
  function automatic logic [7:0] frame_checksum(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] b4,
    input logic [7:0] b5,
    input logic [7:0] b6
  );
    logic [7:0] sum;
    sum = b1 + b2;
    sum = sum + b3;
    sum = sum + b4;
    sum = sum + b5;
    sum = sum + b6;
    return sum;
  endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT_CYC-th consecutive enabled cycle.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign o_expired  = i_en && w_at_limit;

  // Idle counter; holds at the limit until the controller clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// Drains the UART RX FIFO, assembles 8-byte command frames, validates sync,
// opcode and checksum, and issues config writes or sweep start/stop strobes.
module uart_cmd_frame_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk_50m,
  input  logic                 reset_n,
  input  logic [7:0]           fifo_data_out,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 cfg_valid,
  input  logic                 cfg_ready,
  output logic [7:0]           cfg_addr,
  output logic [31:0]          cfg_wdata,
  output logic                 sweep_start,
  output logic                 sweep_stop,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [2:0]           IDX_LAST = 3'(FRAME_LEN - 1);

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [7:0]            r_buf [0:FRAME_LEN-1];
  logic                  r_cfg_valid;
  logic [7:0]            r_cfg_addr;
  logic [31:0]           r_cfg_wdata;
  logic                  r_sweep_start;
  logic                  r_sweep_stop;
  logic                  r_frame_ok;
  logic                  r_frame_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic                  w_pop;
  logic                  w_tmo_clear;
  logic                  w_tmo_en;
  logic                  w_expired;
  logic                  w_cks_ok;
  logic                  w_op_ok;
  logic                  w_frame_good;
  logic [ERR_CNT_W-1:0]  w_err_next;

  // Pop is decoded from state so the byte lands exactly one cycle later in S_CAPT;
  // S_CAPT always follows a pop, so back-to-back pops cannot occur.
  assign w_pop       = ((r_state == S_HUNT) || (r_state == S_POP)) && !fifo_empty;
  assign w_tmo_clear = w_pop || (r_state != S_POP);
  assign w_tmo_en    = (r_state == S_POP) && fifo_empty;

  assign w_cks_ok = (frame_checksum(r_buf[1], r_buf[2], r_buf[3],
                                    r_buf[4], r_buf[5], r_buf[6]) == r_buf[7]);
  assign w_op_ok  = (r_buf[1] == OP_WRITE) || (r_buf[1] == OP_START) ||
                    (r_buf[1] == OP_STOP);
  assign w_frame_good = w_cks_ok && w_op_ok && (r_buf[0] == SYNC_BYTE);
  assign w_err_next   = (r_err_cnt == ERR_MAX) ? r_err_cnt : (r_err_cnt + ERR_ONE);

  frame_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk     (clk_50m),
    .i_rst_n   (reset_n),
    .i_clear   (w_tmo_clear),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // Frame FSM with all result outputs registered.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_HUNT;
      r_idx         <= 3'd0;
      r_cfg_valid   <= 1'b0;
      r_cfg_addr    <= 8'h00;
      r_cfg_wdata   <= 32'h0000_0000;
      r_sweep_start <= 1'b0;
      r_sweep_stop  <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_cnt     <= '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_sweep_start <= 1'b0;
      r_sweep_stop  <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_HUNT: begin
          r_idx   <= 3'd0;
          r_state <= fifo_empty ? S_HUNT : S_CAPT;
        end
        S_POP: begin
          if (w_expired) begin
            r_frame_err <= 1'b1;
            r_err_cnt   <= w_err_next;
            r_idx       <= 3'd0;
            r_state     <= S_HUNT;
          end else if (!fifo_empty) begin
            r_state <= S_CAPT;
          end else begin
            r_state <= S_POP;
          end
        end
        S_CAPT: begin
          r_buf[r_idx] <= fifo_data_out;
          if ((r_idx == 3'd0) && (fifo_data_out != SYNC_BYTE)) begin
            r_state <= S_HUNT;
          end else if (r_idx == IDX_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_POP;
          end
        end
        S_CHECK: begin
          r_idx <= 3'd0;
          if (!w_frame_good) begin
            r_frame_err <= 1'b1;
            r_err_cnt   <= w_err_next;
            r_state     <= S_HUNT;
          end else begin
            case (r_buf[1])
              OP_WRITE: begin
                r_cfg_valid <= 1'b1;
                r_cfg_addr  <= r_buf[2];
                r_cfg_wdata <= {r_buf[3], r_buf[4], r_buf[5], r_buf[6]};
                r_state     <= S_ISSUE;
              end
              OP_START: begin
                r_sweep_start <= 1'b1;
                r_frame_ok    <= 1'b1;
                r_state       <= S_HUNT;
              end
              OP_STOP: begin
                r_sweep_stop <= 1'b1;
                r_frame_ok   <= 1'b1;
                r_state      <= S_HUNT;
              end
              default: begin
                r_frame_err <= 1'b1;
                r_err_cnt   <= w_err_next;
                r_state     <= S_HUNT;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (cfg_ready) begin
            r_cfg_valid <= 1'b0;
            r_frame_ok  <= 1'b1;
            r_state     <= S_HUNT;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        default: begin
          r_cfg_valid <= 1'b0;
          r_idx       <= 3'd0;
          r_state     <= S_HUNT;
        end
      endcase
    end
  end

  assign fifo_rd_en  = w_pop;
  assign cfg_valid   = r_cfg_valid;
  assign cfg_addr    = r_cfg_addr;
  assign cfg_wdata   = r_cfg_wdata;
  assign sweep_start = r_sweep_start;
  assign sweep_stop  = r_sweep_stop;
  assign frame_ok    = r_frame_ok;
  assign frame_err   = r_frame_err;
  assign err_cnt     = r_err_cnt;
  assign busy        = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
// Scoreboard bench for uart_cmd_frame_ctrl: a FIFO model feeds directed frames,
// expected events are queued at stimulus time and matched by a monitor.
module tb_uart_cmd_frame_ctrl;

  localparam int TMO = 64;

  localparam int EV_WRITE = 0;
  localparam int EV_OK    = 1;
  localparam int EV_START = 2;
  localparam int EV_STOP  = 3;
  localparam int EV_ERR   = 4;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  cnt;
  } ev_t;

  logic        clk_50m = 1'b0;
  logic        reset_n;
  logic [7:0]  fifo_data_out;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        sweep_start;
  logic        sweep_stop;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q [$];
  logic [7:0] fifo_q [$];

  uart_cmd_frame_ctrl #(
    .CLK_HZ      (50_000_000),
    .TIMEOUT_CYC (TMO),
    .ERR_CNT_W   (8)
  ) dut (
    .clk_50m       (clk_50m),
    .reset_n       (reset_n),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .sweep_start   (sweep_start),
    .sweep_stop    (sweep_stop),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt),
    .busy          (busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] addr,
                           input logic [31:0] data, input logic [7:0] cnt);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] addr,
                         input logic [31:0] data, input logic [7:0] cnt);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_WRITE) begin
        check("cfg_addr", {24'h0, addr}, {24'h0, e.addr});
        check("cfg_wdata", data, e.data);
      end
      if (kind == EV_ERR) check("err_cnt", {24'h0, cnt}, {24'h0, e.cnt});
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] b [8]);
    for (int i = 0; i < 8; i++) fifo_q.push_back(b[i]);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      tick(1);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_cfg_valid(input int budget);
    int n;
    n = 0;
    while (!cfg_valid && (n < budget)) begin
      tick(1);
      n++;
    end
    check("cfg_valid_seen", {31'h0, cfg_valid}, 32'h1);
  endtask

  // FIFO model: read data appears the cycle after a sampled pop.
  always begin
    logic pop_now, emp_now;
    @(posedge clk_50m);
    pop_now = fifo_rd_en;
    emp_now = fifo_empty;
    #1;
    if (pop_now) begin
      check("rd_en_while_empty", {31'h0, emp_now}, 32'h0);
      if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Output monitor: matches DUT events against the scoreboard queue.
  logic        stall_prev = 1'b0;
  logic [7:0]  hold_addr;
  logic [31:0] hold_data;
  always @(negedge clk_50m) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'h0, cfg_valid}, 32'h1);
        check("hold_addr", {24'h0, cfg_addr}, {24'h0, hold_addr});
        check("hold_wdata", cfg_wdata, hold_data);
      end
      if (cfg_valid && cfg_ready) observe(EV_WRITE, cfg_addr, cfg_wdata, err_cnt);
      if (sweep_start) begin
        check("ok_with_start", {31'h0, frame_ok}, 32'h1);
        observe(EV_START, 8'h00, 32'h0, err_cnt);
      end
      if (sweep_stop) begin
        check("ok_with_stop", {31'h0, frame_ok}, 32'h1);
        observe(EV_STOP, 8'h00, 32'h0, err_cnt);
      end
      if (frame_ok && !sweep_start && !sweep_stop) observe(EV_OK, 8'h00, 32'h0, err_cnt);
      if (frame_err) observe(EV_ERR, 8'h00, 32'h0, err_cnt);
      stall_prev = cfg_valid && !cfg_ready;
      hold_addr  = cfg_addr;
      hold_data  = cfg_wdata;
    end
  end

  initial begin
    logic [7:0] f_wr1  [8] = '{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h25};
    logic [7:0] f_bad  [8] = '{8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h26};
    logic [7:0] f_wr2  [8] = '{8'hA5, 8'h01, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h59};
    logic [7:0] f_start[8] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    logic [7:0] f_stop [8] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};

    reset_n       = 1'b0;
    cfg_ready     = 1'b1;
    fifo_empty    = 1'b1;
    fifo_data_out = 8'h00;
    #35;
    check("rst_cfg_valid", {31'h0, cfg_valid}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    check("rst_pulses", {28'h0, sweep_start, sweep_stop, frame_ok, frame_err}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // WRITE with the sink stalled for 5 cycles
    cfg_ready = 1'b0;
    expect_ev(EV_WRITE, 8'h10, 32'h1234_5678, 8'h00);
    expect_ev(EV_OK, 8'h00, 32'h0, 8'h00);
    push_frame(f_wr1);
    wait_cfg_valid(100);
    tick(5);
    cfg_ready = 1'b1;
    wait_drain(50);

    // START then STOP
    expect_ev(EV_START, 8'h00, 32'h0, 8'h00);
    expect_ev(EV_STOP, 8'h00, 32'h0, 8'h00);
    push_frame(f_start);
    push_frame(f_stop);
    wait_drain(100);

    // Bad checksum, then a good WRITE
    expect_ev(EV_ERR, 8'h00, 32'h0, 8'h01);
    expect_ev(EV_WRITE, 8'h20, 32'hDEAD_BEEF, 8'h00);
    expect_ev(EV_OK, 8'h00, 32'h0, 8'h00);
    push_frame(f_bad);
    push_frame(f_wr2);
    wait_drain(100);

    // Leading garbage is dropped without an error
    expect_ev(EV_START, 8'h00, 32'h0, 8'h00);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    push_frame(f_start);
    wait_drain(100);
    check("garbage_err_cnt", {24'h0, err_cnt}, 32'h1);

    // Mid-frame stall triggers a timeout
    expect_ev(EV_ERR, 8'h00, 32'h0, 8'h02);
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h10);
    wait_drain(TMO + 40);
    tick(1);
    check("timeout_busy", {31'h0, busy}, 32'h0);
    expect_ev(EV_STOP, 8'h00, 32'h0, 8'h00);
    push_frame(f_stop);
    wait_drain(100);

    // Reset while holding a config write
    cfg_ready = 1'b0;
    push_frame(f_wr1);
    wait_cfg_valid(100);
    check("issue_busy", {31'h0, busy}, 32'h1);
    @(negedge clk_50m);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_cfg_valid", {31'h0, cfg_valid}, 32'h0);
    check("async_rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    tick(3);
    reset_n   = 1'b1;
    cfg_ready = 1'b1;
    tick(10);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_cfg_valid", {31'h0, cfg_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
